port_arbiter: RTL
=================

PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one resource instance (range 2..8).
REQ-002 Parameter HOLD_MAX, default 8: maximum consecutive cycles one owner may hold the grant (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester access request, level-sensitive.
REQ-006 c_in  input  NUM_REQ  per-requester value for the resource C input.
REQ-007 d_in  input  NUM_REQ  per-requester value for the resource D input.
REQ-008 grant  output  NUM_REQ  one-hot grant to the current owner, registered.
REQ-009 res_c  output  1  drives the shared resource C input.
REQ-010 res_d  output  1  drives the shared resource D input.
REQ-011 res_a  input  1  shared resource A output, returned to the owner.
REQ-012 a_out  output  NUM_REQ  res_a routed to the owner's bit, registered; other bits 0.
REQ-013 a_valid  output  1  a_out carries a valid capture this cycle.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States: IDLE, GRANT, GAP; encoding fixed in the package.
REQ-016 IDLE: if any req bit is high, select a winner round-robin starting from (last_owner+1) mod NUM_REQ; next cycle grant = winner, state = GRANT, hold count = 1.
REQ-017 Latency: req asserted at edge N into an idle arbiter -> grant high after edge N+1.
REQ-018 GRANT: owner keeps grant while req[owner]=1 and hold count < HOLD_MAX; hold count increments each GRANT cycle, saturating at HOLD_MAX.
REQ-019 GRANT exit: req[owner] low or hold count = HOLD_MAX -> state GAP, grant = 0, last_owner = owner.
REQ-020 GAP lasts exactly one cycle with grant = 0, res_c = 0, res_d = 0; then IDLE, arbitrating the same cycle per REQ-016.
REQ-021 res_c/res_d = c_in[owner]/d_in[owner] combinationally while in GRANT; 0 otherwise.
REQ-022 a_out/a_valid: res_a sampled at each GRANT cycle edge and presented one cycle later at the owner bit with a_valid = 1; a_valid = 0 otherwise.
REQ-023 grant is never multi-hot; no requester is granted twice consecutively while another req is high at arbitration time.
REQ-024 Requests arriving during GRANT or GAP wait; no pre-emption, no queue beyond req levels.
REQ-025 Single requester continuously high: grant pattern HOLD_MAX on, 1 off, repeating.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, grant 0, res_c 0, res_d 0, a_out 0, a_valid 0, busy 0, hold count 0, last_owner NUM_REQ-1 (first winner is requester 0).
REQ-027 Reset asserted mid-GRANT drops grant immediately; no GAP cycle follows release.
REQ-028 First arbitration occurs on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro PORT_ARBITER_TIMEOUT_EN: when defined, HOLD_MAX limit of REQ-018/019 is enforced.
REQ-030 Without PORT_ARBITER_TIMEOUT_EN: owner holds until req[owner] drops; hold counter omitted; HOLD_MAX ignored.

Structure
REQ-031 Package port_arbiter_pkg holds the state encoding constants and the NUM_REQ/HOLD_MAX defaults.
REQ-032 Sub-module rr_pick: combinational round-robin selector (req vector, last_owner -> one-hot winner, any flag), instantiated once.

Verification
REQ-033 Reset then req=4'b0001 held -> grant=4'b0001 after 1 edge, released after 8 cycles (TIMEOUT_EN), 1-cycle GAP, re-granted.
REQ-034 req=4'b1111 held -> grants cycle 0,1,2,3,0 with a GAP between each, never multi-hot.
REQ-035 Owner 2, c_in[2]=1, d_in[2]=0, res_a=1 -> res_c=1, res_d=0, next cycle a_out=4'b0100, a_valid=1.
REQ-036 rst_n pulsed low mid-GRANT -> grant, a_out, busy 0 without waiting for clk; after release requester 0 wins first.
REQ-037 Without PORT_ARBITER_TIMEOUT_EN, req=4'b0011 held 20 cycles -> requester 0 holds all 20 cycles; requester 1 granted 2 edges after req[0] drops.

Source files
------------

// File: rtl/port_arbiter_pkg.sv
// Shared constants for the port arbiter: state encoding and default sizing.
// Optional hold-limit feature is enabled with PORT_ARBITER_TIMEOUT_EN.
package port_arbiter_pkg;

   localparam int unsigned NUM_REQ_DEF  = 4;
   localparam int unsigned HOLD_MAX_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/port_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after last_owner wins.
// Instantiated once by port_arbiter.
module rr_pick
   import port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   localparam int unsigned IW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_owner,
   output logic [NUM_REQ-1:0] winner,
   output logic               any
);

   logic [IW-1:0] k;

   always_comb begin
      winner = '0;
      any    = 1'b0;
      k      = '0;
      // Scan starts one past the last owner, so the last owner comes last.
      for (int i = 1; i <= NUM_REQ; i++) begin
         k = IW'((int'(last_owner) + i) % NUM_REQ);
         if (!any && req[k]) begin
            winner[k] = 1'b1;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/port_arbiter.sv
// Round-robin arbiter sharing one resource among NUM_REQ requesters.
// Define PORT_ARBITER_TIMEOUT_EN to limit a grant to HOLD_MAX cycles.
module port_arbiter
   import port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
   parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] c_in,
   input  logic [NUM_REQ-1:0] d_in,
   output logic [NUM_REQ-1:0] grant,
   output logic               res_c,
   output logic               res_d,
   input  logic               res_a,
   output logic [NUM_REQ-1:0] a_out,
   output logic               a_valid,
   output logic               busy
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   arb_state_e         state;
   logic [IW-1:0]      owner;
   logic [IW-1:0]      last_owner;
   logic [NUM_REQ-1:0] winner;
   logic               any;
   logic [IW-1:0]      win_idx;
   logic               stay;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .winner     (winner),
      .any        (any)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) win_idx = IW'(i);
      end
   end

`ifdef PORT_ARBITER_TIMEOUT_EN
   logic [7:0] hold_cnt;

   assign stay = req[owner] && (hold_cnt < 8'(HOLD_MAX));
`else
   // Hold limit is absent here; the owner keeps the grant until it lets go.
   localparam bit HOLD_ON = (HOLD_MAX > 0);

   assign stay = req[owner] && HOLD_ON;
`endif

   assign busy  = (state != ST_IDLE);
   assign res_c = (state == ST_GRANT) && c_in[owner];
   assign res_d = (state == ST_GRANT) && d_in[owner];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         grant      <= '0;
         owner      <= '0;
         last_owner <= IW'(NUM_REQ - 1);
         a_out      <= '0;
         a_valid    <= 1'b0;
`ifdef PORT_ARBITER_TIMEOUT_EN
         hold_cnt   <= '0;
`endif
      end else begin
         a_out   <= '0;
         a_valid <= 1'b0;
         unique case (state)
            // GAP arbitrates directly so a lone requester sees one idle cycle.
            ST_IDLE, ST_GAP: begin
               if (any) begin
                  state <= ST_GRANT;
                  grant <= winner;
                  owner <= win_idx;
`ifdef PORT_ARBITER_TIMEOUT_EN
                  hold_cnt <= 8'd1;
`endif
               end else begin
                  state <= ST_IDLE;
                  grant <= '0;
               end
            end
            ST_GRANT: begin
               a_valid      <= 1'b1;
               a_out[owner] <= res_a;
               if (stay) begin
`ifdef PORT_ARBITER_TIMEOUT_EN
                  hold_cnt <= hold_cnt + 8'd1;
`endif
               end else begin
                  state      <= ST_GAP;
                  grant      <= '0;
                  last_owner <= owner;
               end
            end
            default: begin
               state <= ST_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule
